uart_dev: RTL and testbench
===========================

Name: uart_dev

Overview:
- Bridge-attached UART peripheral: the responder side of the bridge device interface.
- Uses the same device-port contract as the timers: 2-bit word address, write_enable, write_data, combinational read_result, level irq.
- Contains an 8N1 serial transmitter and a serial receiver, each with a single-byte buffer. It drives one hwirq line via the bridge.
- The bridge handles address decoding, alignment checks and write gating (stop, valid); this block only sees legal word accesses.

Parameters:
- DEFAULT_DIV, 16, reset value of the DIVISOR register, in clocks per bit.
- MIN_DIV, 4, smallest effective divisor. Smaller programmed values behave as MIN_DIV.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- addr  in  2  word offset within device (bridge slices addr[3:2])
- write_enable  in  1  single-cycle write strobe, already gated by bridge
- write_data  in  32  write value
- read_result  out  32  combinational read of the register at addr
- irq  out  1  level interrupt to the bridge hwirq vector
- rxd  in  1  serial input, asynchronous to clk
- txd  out  1  serial output, idle high

Behaviour:
- Register map (addr):
  - 0 CTRL: [0] tx_irq_en, [1] rx_irq_en. Other bits read 0.
  - 1 DIVISOR: [15:0]. Effective value is max(DIVISOR, MIN_DIV).
  - 2 TXDATA: read returns {24'b0, last byte written}.
  - 3 STATUS: read returns {20'b0, frame_err[11], overrun[10], rx_valid[9], tx_busy[8], rx_data[7:0]}. Any write clears rx_valid, overrun and frame_err.
- Reset values: CTRL=0, DIVISOR=DEFAULT_DIV, TXDATA=0, rx_data=0, all flags 0, txd=1, irq=0, both FSMs in IDLE.
- Writes take effect at the next clk edge. Reads have no side effects.
- irq = (tx_irq_en & ~tx_busy) | (rx_irq_en & rx_valid), registered-free combinational from flops.
- TX FSM (IDLE, START, DATA, STOP):
  - A write to TXDATA in IDLE latches the byte and the effective divisor, then enters START. txd=0 from the next cycle.
  - Each state lasts exactly div cycles. DATA sends 8 bits LSB first using a 3-bit counter. STOP drives txd=1 for div cycles, then returns to IDLE.
  - tx_busy=1 in every state except IDLE.
  - A write to TXDATA while busy is ignored: neither the register nor the frame changes.
- RX path:
  - rxd passes through a 2-flop synchronizer.
  - IDLE: a synchronized falling edge latches div and enters START.
  - START: sample at div/2 (floor). If the sample is 1 it is a false start: return to IDLE with no flag.
  - DATA: sample every div cycles, 8 bits, LSB first.
  - STOP: sample after div cycles.
    - Stop bit 1: load rx_data and set rx_valid. If rx_valid was already 1, also set overrun; the new byte overwrites the old one.
    - Stop bit 0: discard the byte, set frame_err, leave rx_data unchanged.
  - Return to IDLE in the same cycle.
- Divisor writes mid-frame do not affect the frame in flight. They apply from the next frame.
- Simultaneous STATUS write and RX completion: the clear applies first, then the completion. Result: rx_valid=1, overrun=0, rx_data=new byte.
- Reset asserted mid-frame: both FSMs abort immediately, txd=1, no partial byte is stored.

Optional Feature:
- UART_PARITY_EN
  - Defined: CTRL[2] enables an even parity bit between the last data bit and stop (TX and RX, a PARITY state in both FSMs). A mismatch on RX discards the byte and sets parity_err at STATUS[12], which is cleared by a STATUS write.
  - Undefined: CTRL[2] and STATUS[12] read 0, and no PARITY state exists.

Decomposition:
- Shared package/header uart.h:
  - register offsets (UART_CTRL, UART_DIV, UART_TXDATA, UART_STATUS)
  - STATUS bit positions
  - FSM state encodings
  - bridge address window constants BRIDGE_UART_LB/UB/BASE (added to bridge.h)
- Sub-modules: uart_tx (FSM, shift register, bit timer). RX stays in uart_dev.

Test Plan:
- Reset, then read all four offsets → CTRL=0, DIVISOR=16, TXDATA=0, STATUS=0. txd=1, irq=0.
- DIVISOR=4, write TXDATA=0xA5 → txd=0 for 4 cycles starting 1 cycle after the write, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then 1. tx_busy is 1 for exactly 40 cycles.
- Loop txd to rxd, DIVISOR=8, CTRL=2, send 0x3C → STATUS=0x23C, irq=1. Write STATUS → STATUS=0x000, irq=0.
- Receive 0x11 then 0x22 without clearing → STATUS bits [10:9]=11, rx_data=0x22.
- Drive a frame with stop bit 0 → frame_err=1, rx_valid=0. Drive a 1-cycle low glitch on rxd with DIVISOR=8 → no state change.
- Write TXDATA=0x55 while busy sending 0x0F → the line carries only 0x0F, TXDATA reads 0x0F. Assert rst mid-frame → txd=1 on the next cycle, tx_busy=0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared constants for the bridge-attached UART: register offsets, STATUS/CTRL bit
// positions, FSM encodings and the bridge window. UART_PARITY_EN adds the PARITY state.
package uart_pkg;

    localparam int UART_DEFAULT_DIV = 16;
    localparam int UART_MIN_DIV     = 4;

    localparam logic [1:0] UART_CTRL   = 2'd0;
    localparam logic [1:0] UART_DIV    = 2'd1;
    localparam logic [1:0] UART_TXDATA = 2'd2;
    localparam logic [1:0] UART_STATUS = 2'd3;

    localparam int CTRL_TX_IRQ_EN = 0;
    localparam int CTRL_RX_IRQ_EN = 1;
    localparam int CTRL_PARITY_EN = 2;

    localparam int ST_TX_BUSY    = 8;
    localparam int ST_RX_VALID   = 9;
    localparam int ST_OVERRUN    = 10;
    localparam int ST_FRAME_ERR  = 11;
    localparam int ST_PARITY_ERR = 12;

    localparam logic [31:0] BRIDGE_UART_BASE = 32'h0000_0040;
    localparam logic [31:0] BRIDGE_UART_LB   = 32'h0000_0040;
    localparam logic [31:0] BRIDGE_UART_UB   = 32'h0000_004F;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3
`ifdef UART_PARITY_EN
        , ST_PARITY = 3'd4
`endif
    } uart_state_e;

endpackage

// File: rtl/uart_tx.sv
// 8N1 serial transmitter: one bit timer, 3-bit bit counter and shift register.
// With UART_PARITY_EN an even parity bit can follow the data bits.
module uart_tx
    import uart_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  data,
    input  logic [15:0] div,
`ifdef UART_PARITY_EN
    input  logic        parity_en,
`endif
    output logic        txd,
    output uart_state_e state
);

    uart_state_e state_q;
    logic [15:0] div_q;
    logic [15:0] cnt_q;
    logic [7:0]  shift_q;
    logic [2:0]  bit_q;
    logic        txd_q;
`ifdef UART_PARITY_EN
    logic        par_en_q;
    logic        par_q;
`endif
    logic        bit_end;

    assign bit_end = (cnt_q == div_q - 16'd1);
    assign txd     = txd_q;
    assign state   = state_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            div_q   <= 16'd1;
            cnt_q   <= '0;
            shift_q <= '0;
            bit_q   <= '0;
            txd_q   <= 1'b1;
`ifdef UART_PARITY_EN
            par_en_q <= 1'b0;
            par_q    <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        div_q   <= div;
                        shift_q <= data;
                        cnt_q   <= '0;
                        bit_q   <= '0;
                        txd_q   <= 1'b0;
                        state_q <= ST_START;
`ifdef UART_PARITY_EN
                        par_en_q <= parity_en;
                        par_q    <= ^data;
`endif
                    end
                end
                ST_START: begin
                    if (bit_end) begin
                        cnt_q   <= '0;
                        txd_q   <= shift_q[0];
                        state_q <= ST_DATA;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                ST_DATA: begin
                    if (bit_end) begin
                        cnt_q   <= '0;
                        bit_q   <= bit_q + 3'd1;
                        shift_q <= {1'b0, shift_q[7:1]};
                        if (bit_q == 3'd7) begin
`ifdef UART_PARITY_EN
                            txd_q   <= par_en_q ? par_q : 1'b1;
                            state_q <= par_en_q ? ST_PARITY : ST_STOP;
`else
                            txd_q   <= 1'b1;
                            state_q <= ST_STOP;
`endif
                        end else begin
                            txd_q <= shift_q[1];
                        end
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
`ifdef UART_PARITY_EN
                ST_PARITY: begin
                    if (bit_end) begin
                        cnt_q   <= '0;
                        txd_q   <= 1'b1;
                        state_q <= ST_STOP;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
`endif
                ST_STOP: begin
                    if (bit_end) begin
                        cnt_q   <= '0;
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                default: begin
                    txd_q   <= 1'b1;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/uart_dev.sv
// UART responder on the bridge device port: CTRL/DIVISOR/TXDATA/STATUS, TX via uart_tx,
// RX FSM kept here. Define UART_PARITY_EN to enable the even-parity option on CTRL[2].
module uart_dev
    import uart_pkg::*;
#(
    parameter int DEFAULT_DIV = UART_DEFAULT_DIV,
    parameter int MIN_DIV     = UART_MIN_DIV
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  addr,
    input  logic        write_enable,
    input  logic [31:0] write_data,
    output logic [31:0] read_result,
    output logic        irq,
    input  logic        rxd,
    output logic        txd
);

`ifdef UART_PARITY_EN
    localparam int CTRL_W = 3;
`else
    localparam int CTRL_W = 2;
`endif

    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [15:0]       div_q, div_d;
    logic [7:0]        txdata_q, txdata_d;
    logic [15:0]       div_eff;
    logic              wr_ctrl, wr_div, wr_tx, wr_status, tx_start, tx_busy;
    uart_state_e       tx_state;
    logic              unused_wdata;

    assign wr_ctrl   = write_enable && (addr == UART_CTRL);
    assign wr_div    = write_enable && (addr == UART_DIV);
    assign wr_tx     = write_enable && (addr == UART_TXDATA);
    assign wr_status = write_enable && (addr == UART_STATUS);
    assign tx_busy   = (tx_state != ST_IDLE);
    assign tx_start  = wr_tx && !tx_busy;
    assign div_eff   = (div_q < 16'(MIN_DIV)) ? 16'(MIN_DIV) : div_q;
    assign unused_wdata = ^write_data[31:16];

    always_comb begin
        ctrl_d   = ctrl_q;
        div_d    = div_q;
        txdata_d = txdata_q;
        if (wr_ctrl)  ctrl_d   = write_data[CTRL_W-1:0];
        if (wr_div)   div_d    = write_data[15:0];
        if (tx_start) txdata_d = write_data[7:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ctrl_q   <= '0;
            div_q    <= 16'(DEFAULT_DIV);
            txdata_q <= '0;
        end else begin
            ctrl_q   <= ctrl_d;
            div_q    <= div_d;
            txdata_q <= txdata_d;
        end
    end

    uart_tx u_tx (
        .clk       (clk),
        .rst       (rst),
        .start     (tx_start),
        .data      (write_data[7:0]),
        .div       (div_eff),
`ifdef UART_PARITY_EN
        .parity_en (ctrl_q[CTRL_PARITY_EN]),
`endif
        .txd       (txd),
        .state     (tx_state)
    );

    uart_state_e rx_state_q;
    logic        rx_s1_q, rx_s2_q, rx_prev_q;
    logic [15:0] rx_div_q, rx_cnt_q;
    logic [2:0]  rx_bit_q;
    logic [7:0]  rx_shift_q, rx_data_q;
    logic        rx_valid_q, rx_overrun_q, rx_frame_err_q;
`ifdef UART_PARITY_EN
    logic        rx_par_en_q, rx_par_bad_q, rx_parity_err_q;
`endif
    logic        rx_tick;

    assign rx_tick = (rx_cnt_q == rx_div_q - 16'd1);

    // STATUS clear is written before the FSM so a completing frame in the same cycle wins.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_s1_q        <= 1'b1;
            rx_s2_q        <= 1'b1;
            rx_prev_q      <= 1'b1;
            rx_state_q     <= ST_IDLE;
            rx_div_q       <= 16'd1;
            rx_cnt_q       <= '0;
            rx_bit_q       <= '0;
            rx_shift_q     <= '0;
            rx_data_q      <= '0;
            rx_valid_q     <= 1'b0;
            rx_overrun_q   <= 1'b0;
            rx_frame_err_q <= 1'b0;
`ifdef UART_PARITY_EN
            rx_par_en_q     <= 1'b0;
            rx_par_bad_q    <= 1'b0;
            rx_parity_err_q <= 1'b0;
`endif
        end else begin
            rx_s1_q   <= rxd;
            rx_s2_q   <= rx_s1_q;
            rx_prev_q <= rx_s2_q;
            if (wr_status) begin
                rx_valid_q     <= 1'b0;
                rx_overrun_q   <= 1'b0;
                rx_frame_err_q <= 1'b0;
`ifdef UART_PARITY_EN
                rx_parity_err_q <= 1'b0;
`endif
            end
            case (rx_state_q)
                ST_IDLE: begin
                    if (rx_prev_q && !rx_s2_q) begin
                        rx_div_q   <= div_eff;
                        rx_cnt_q   <= '0;
                        rx_state_q <= ST_START;
`ifdef UART_PARITY_EN
                        rx_par_en_q  <= ctrl_q[CTRL_PARITY_EN];
                        rx_par_bad_q <= 1'b0;
`endif
                    end
                end
                ST_START: begin
                    if (rx_cnt_q == {1'b0, rx_div_q[15:1]}) begin
                        rx_cnt_q   <= '0;
                        rx_bit_q   <= '0;
                        rx_state_q <= rx_s2_q ? ST_IDLE : ST_DATA;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + 16'd1;
                    end
                end
                ST_DATA: begin
                    if (rx_tick) begin
                        rx_cnt_q   <= '0;
                        rx_bit_q   <= rx_bit_q + 3'd1;
                        rx_shift_q <= {rx_s2_q, rx_shift_q[7:1]};
                        if (rx_bit_q == 3'd7) begin
`ifdef UART_PARITY_EN
                            rx_state_q <= rx_par_en_q ? ST_PARITY : ST_STOP;
`else
                            rx_state_q <= ST_STOP;
`endif
                        end
                    end else begin
                        rx_cnt_q <= rx_cnt_q + 16'd1;
                    end
                end
`ifdef UART_PARITY_EN
                ST_PARITY: begin
                    if (rx_tick) begin
                        rx_cnt_q     <= '0;
                        rx_par_bad_q <= (rx_s2_q != ^rx_shift_q);
                        rx_state_q   <= ST_STOP;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + 16'd1;
                    end
                end
`endif
                ST_STOP: begin
                    if (rx_tick) begin
                        rx_cnt_q   <= '0;
                        rx_state_q <= ST_IDLE;
                        if (!rx_s2_q) begin
                            rx_frame_err_q <= 1'b1;
`ifdef UART_PARITY_EN
                        end else if (rx_par_bad_q) begin
                            rx_parity_err_q <= 1'b1;
`endif
                        end else begin
                            rx_data_q  <= rx_shift_q;
                            rx_valid_q <= 1'b1;
                            if (rx_valid_q && !wr_status) rx_overrun_q <= 1'b1;
                        end
                    end else begin
                        rx_cnt_q <= rx_cnt_q + 16'd1;
                    end
                end
                default: rx_state_q <= ST_IDLE;
            endcase
        end
    end

    logic [31:0] status_word;

    always_comb begin
        status_word               = '0;
        status_word[7:0]          = rx_data_q;
        status_word[ST_TX_BUSY]   = tx_busy;
        status_word[ST_RX_VALID]  = rx_valid_q;
        status_word[ST_OVERRUN]   = rx_overrun_q;
        status_word[ST_FRAME_ERR] = rx_frame_err_q;
`ifdef UART_PARITY_EN
        status_word[ST_PARITY_ERR] = rx_parity_err_q;
`endif
    end

    always_comb begin
        read_result = '0;
        case (addr)
            UART_CTRL:   read_result[CTRL_W-1:0] = ctrl_q;
            UART_DIV:    read_result[15:0]       = div_q;
            UART_TXDATA: read_result[7:0]        = txdata_q;
            default:     read_result             = status_word;
        endcase
    end

    assign irq = (ctrl_q[CTRL_TX_IRQ_EN] & ~tx_busy) | (ctrl_q[CTRL_RX_IRQ_EN] & rx_valid_q);

endmodule

// File: tb/tb_uart_dev.sv
// Bench for uart_dev: bus driver tasks, serial line driver, TX frame scoreboard fed by an
// expected queue and decoded by a line monitor, plus a byte-level model of the RX flags.
module tb_uart_dev;
    import uart_pkg::*;

    localparam int W = 24;  // {effective divisor[15:0], byte[7:0]}

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  addr = 2'd0;
    logic        write_enable = 1'b0;
    logic [31:0] write_data = 32'd0;
    logic [31:0] read_result;
    logic        irq;
    logic        rxd;
    logic        txd;
    logic        rxd_drv = 1'b1;
    logic        loop_en = 1'b0;

    assign rxd = loop_en ? txd : rxd_drv;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    uart_dev dut (
        .clk          (clk),
        .rst          (rst),
        .addr         (addr),
        .write_enable (write_enable),
        .write_data   (write_data),
        .read_result  (read_result),
        .irq          (irq),
        .rxd          (rxd),
        .txd          (txd)
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [W-1:0] exp_q[$];
    bit          mon_busy = 1'b0;

    // reference model of the register/flag state
    logic [1:0]  m_ctrl;
    logic [7:0]  m_rx_data;
    logic        m_valid, m_ovr, m_fe;

    function automatic void m_reset();
        m_ctrl = 2'd0; m_rx_data = 8'd0; m_valid = 1'b0; m_ovr = 1'b0; m_fe = 1'b0;
    endfunction

    function automatic void m_clear();
        m_valid = 1'b0; m_ovr = 1'b0; m_fe = 1'b0;
    endfunction

    function automatic void m_rx_frame(input logic [7:0] b, input logic stop);
        if (stop) begin
            if (m_valid) m_ovr = 1'b1;
            m_valid   = 1'b1;
            m_rx_data = b;
        end else begin
            m_fe = 1'b1;
        end
    endfunction

    function automatic logic [31:0] m_status();
        return {20'd0, m_fe, m_ovr, m_valid, 1'b0, m_rx_data};
    endfunction

    function automatic int eff_div(input int d);
        return (d < 4) ? 4 : d;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic reg_write(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        addr = a; write_data = d; write_enable = 1'b1;
        @(negedge clk);
        write_enable = 1'b0;
    endtask

    task automatic reg_read(input logic [1:0] a, output logic [31:0] d);
        addr = a;
        #1;
        d = read_result;
    endtask

    task automatic drive_frame(input logic [7:0] b, input logic stop, input int div);
        logic [9:0] bits;
        bits = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rxd_drv = bits[i];
            repeat (div) @(negedge clk);
        end
        rxd_drv = 1'b1;
        repeat (div + 4) @(negedge clk);
    endtask

    task automatic send_tx(input logic [7:0] b, input int div);
        exp_q.push_back({16'(div), b});
        reg_write(UART_TXDATA, {24'd0, b});
    endtask

    // ---------------- TX line monitor / scoreboard ----------------
    initial begin : tx_monitor
        logic [W-1:0] e;
        logic [9:0]   got;
        int           d;
        bit           aborted;
        forever begin
            @(negedge clk);
            if (rst === 1'b1 && txd === 1'b0) begin
                mon_busy = 1'b1;
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL tx_unexpected_frame: txd went low with no frame expected at %0t", $time);
                    repeat (200) @(negedge clk);
                end else begin
                    e = exp_q.pop_front();
                    d = int'(e[23:8]);
                    aborted = 1'b0;
                    repeat (d / 2) @(negedge clk);
                    got[0] = txd;
                    if (rst !== 1'b1) aborted = 1'b1;
                    for (int i = 1; i < 10; i++) begin
                        repeat (d) @(negedge clk);
                        got[i] = txd;
                        if (rst !== 1'b1) aborted = 1'b1;
                    end
                    if (!aborted) check("tx_frame", {22'd0, got}, {22'd0, 1'b1, e[7:0], 1'b0});
                end
                mon_busy = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "timeout");
    end

    // ---------------- stimulus ----------------
    initial begin : main
        logic [31:0] rd;
        logic [9:0]  frame;
        logic [7:0]  b;
        logic        stop;
        int          d;
        int          cnt;
        logic [31:0] ctrl_mask;

`ifdef UART_PARITY_EN
        ctrl_mask = 32'h7;
`else
        ctrl_mask = 32'h3;
`endif
        m_reset();
        repeat (3) @(negedge clk);
        check("reset_txd_during_rst", {31'd0, txd}, 32'd1);
        rst = 1'b1;
        @(negedge clk);

        reg_read(UART_CTRL, rd);   check("reset_ctrl", rd, 32'd0);
        reg_read(UART_DIV, rd);    check("reset_div", rd, 32'd16);
        reg_read(UART_TXDATA, rd); check("reset_txdata", rd, 32'd0);
        reg_read(UART_STATUS, rd); check("reset_status", rd, 32'd0);
        check("reset_txd", {31'd0, txd}, 32'd1);
        check("reset_irq", {31'd0, irq}, 32'd0);

        reg_write(UART_CTRL, 32'hFFFF_FFFF);
        reg_read(UART_CTRL, rd);   check("ctrl_mask", rd, ctrl_mask);
        check("irq_tx_idle", {31'd0, irq}, 32'd1);
        reg_write(UART_CTRL, 32'd0);
        check("irq_off", {31'd0, irq}, 32'd0);

        // exact TX timing with DIVISOR=4
        reg_write(UART_DIV, 32'd4);
        frame = {1'b1, 8'hA5, 1'b0};
        send_tx(8'hA5, 4);
        for (int i = 0; i <= 40; i++) begin
            if (i > 0) @(negedge clk);
            reg_read(UART_STATUS, rd);
            check("a5_txd", {31'd0, txd}, (i < 40) ? {31'd0, frame[i / 4]} : 32'd1);
            check("a5_busy", {31'd0, rd[8]}, (i < 40) ? 32'd1 : 32'd0);
        end
        reg_read(UART_TXDATA, rd); check("a5_txdata", rd, 32'hA5);

        // random TX bytes and divisors, divisor rewritten mid-frame
        for (int k = 0; k < 6; k++) begin
            d = $urandom_range(0, 12);
            b = 8'($urandom_range(0, 255));
            reg_write(UART_DIV, 32'(d));
            reg_read(UART_DIV, rd); check("div_readback", rd, 32'(d));
            send_tx(b, eff_div(d));
            reg_write(UART_DIV, 32'($urandom_range(0, 12)));
            repeat (10 * eff_div(d) + 4) @(negedge clk);
        end

        // loopback receive
        loop_en = 1'b1;
        reg_write(UART_DIV, 32'd8);
        reg_write(UART_CTRL, 32'd2); m_ctrl = 2'd2;
        send_tx(8'h3C, 8);
        m_rx_frame(8'h3C, 1'b1);
        repeat (90) @(negedge clk);
        reg_read(UART_STATUS, rd); check("loop_status", rd, 32'h23C);
        check("loop_irq", {31'd0, irq}, 32'd1);
        reg_write(UART_STATUS, 32'd0); m_clear();
        reg_read(UART_STATUS, rd); check("loop_clear_flags", rd & 32'hF00, 32'd0);
        check("loop_irq_clear", {31'd0, irq}, 32'd0);
        loop_en = 1'b0;

        // overrun: two frames without clearing
        drive_frame(8'h11, 1'b1, 8); m_rx_frame(8'h11, 1'b1);
        drive_frame(8'h22, 1'b1, 8); m_rx_frame(8'h22, 1'b1);
        reg_read(UART_STATUS, rd); check("overrun_status", rd, m_status());
        check("overrun_bits", {30'd0, rd[10:9]}, 32'd3);

        // framing error
        reg_write(UART_STATUS, 32'd1); m_clear();
        drive_frame(8'h5A, 1'b0, 8); m_rx_frame(8'h5A, 1'b0);
        reg_read(UART_STATUS, rd); check("frame_err_status", rd, m_status());

        // single-cycle glitch is a false start
        @(negedge clk); rxd_drv = 1'b0;
        @(negedge clk); rxd_drv = 1'b1;
        repeat (30) @(negedge clk);
        reg_read(UART_STATUS, rd); check("glitch_status", rd, m_status());

        // randomized receive against the flag model
        for (int k = 0; k < 8; k++) begin
            d = $urandom_range(0, 12);
            b = 8'($urandom_range(0, 255));
            stop = ($urandom_range(0, 3) != 0);
            reg_write(UART_DIV, 32'(d));
            m_ctrl = 2'($urandom_range(0, 3));
            reg_write(UART_CTRL, {30'd0, m_ctrl});
            if ($urandom_range(0, 2) == 0) begin
                reg_write(UART_STATUS, $urandom); m_clear();
            end
            drive_frame(b, stop, eff_div(d));
            m_rx_frame(b, stop);
            reg_read(UART_STATUS, rd); check("rand_rx_status", rd, m_status());
            check("rand_rx_irq", {31'd0, irq}, {31'd0, m_ctrl[0] | (m_ctrl[1] & m_valid)});
        end
        reg_write(UART_CTRL, 32'd0); m_ctrl = 2'd0;

        // write to TXDATA while busy is dropped
        reg_write(UART_DIV, 32'd4);
        send_tx(8'h0F, 4);
        repeat (5) @(negedge clk);
        reg_write(UART_TXDATA, 32'h55);
        reg_read(UART_TXDATA, rd); check("busy_write_ignored", rd, 32'h0F);
        repeat (45) @(negedge clk);

        // reset mid-frame
        reg_write(UART_DIV, 32'd8);
        send_tx(8'($urandom_range(0, 255)), 8);
        repeat (20) @(negedge clk);
        #2 rst = 1'b0;
        #1 check("rst_txd_immediate", {31'd0, txd}, 32'd1);
        @(negedge clk);
        check("rst_txd_next", {31'd0, txd}, 32'd1);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        m_reset();
        @(negedge clk);
        reg_read(UART_STATUS, rd); check("rst_status", rd, 32'd0);
        reg_read(UART_DIV, rd);    check("rst_div", rd, 32'd16);
        check("rst_irq", {31'd0, irq}, 32'd0);

        // drain the TX scoreboard
        cnt = 0;
        while ((exp_q.size() != 0 || mon_busy) && cnt < 3000) begin
            @(negedge clk);
            cnt++;
        end
        check("tx_queue_drained", 32'(exp_q.size()), 32'd0);
        check("tx_monitor_idle", {31'd0, mon_busy}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
